mmh_sum_sequencer: RTL and testbench

Sequencer for the modular summation unit in the MMH-MH privacy-amplification datapath. It collects GAMMA-bit product elements one at a time from the multiplier stage, packs K of them into a flattened frame, fires the summation unit, captures its modular sum and emits it as one hash word. It repeats this for N_BLOCKS frames per key block, then signals completion.

---
 rtl/mmh_pkg.sv | 24 ++
 rtl/mmh_sum_sequencer_if.sv | 40 ++++
 rtl/mmh_frame_packer.sv | 50 +++++
 rtl/mmh_sum_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mmh_sum_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mmh_pkg.sv
// Shared definitions for the MMH-MH summation datapath: sequencer state
// encoding, default datapath geometry and a counter width helper.
package mmh_pkg;

    // Default geometry shared with the multiplier and summation blocks
    localparam int DEF_GAMMA    = 13;
    localparam int DEF_K        = 16;
    localparam int DEF_N_BLOCKS = 8;
    localparam int DEF_TIMEOUT  = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_FIRE,
        ST_WAIT,
        ST_OUT
    } state_t;

    // Width needed to count 0..n-1, never less than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmh_sum_sequencer_if.sv
// Bus bundle between the sequencer and its environment: element stream from
// the multiplier, frame/result exchange with the summation unit, hash word
// stream to the consumer and block status.
interface mmh_sum_sequencer_if
    import mmh_pkg::*;
#(
    parameter int GAMMA = DEF_GAMMA,
    parameter int K     = DEF_K
);
    logic                 start;
    logic                 elem_valid;
    logic [GAMMA-1:0]     elem_data;
    logic                 elem_ready;
    logic                 sum_valid_in;
    logic [GAMMA*K-1:0]   sum_data;
    logic [GAMMA-1:0]     sum_result;
    logic                 sum_valid_out;
    logic                 hash_valid;
    logic [GAMMA-1:0]     hash_data;
    logic                 hash_last;
    logic                 hash_ready;
    logic                 busy;
    logic                 done;
    logic                 err;

    // Environment side: multiplier, summation unit and hash consumer
    modport master (
        output start, elem_valid, elem_data, sum_result, sum_valid_out, hash_ready,
        input  elem_ready, sum_valid_in, sum_data, hash_valid, hash_data, hash_last,
               busy, done, err
    );

    // Sequencer side
    modport slave (
        input  start, elem_valid, elem_data, sum_result, sum_valid_out, hash_ready,
        output elem_ready, sum_valid_in, sum_data, hash_valid, hash_data, hash_last,
               busy, done, err
    );

endinterface

// File: rtl/mmh_frame_packer.sv
// Collects K elements into slot registers and presents them as one flat
// frame. full pulses together with the write into the last slot.
module mmh_frame_packer
    import mmh_pkg::*;
#(
    parameter int GAMMA = DEF_GAMMA,
    parameter int K     = DEF_K
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [GAMMA-1:0]   wr_data,
    output logic [GAMMA*K-1:0] frame,
    output logic               full
);
    localparam int IDX_W = cnt_width(K);

    logic [GAMMA-1:0] slots [K];
    logic [IDX_W-1:0] elem_idx;
    logic             at_last;

    assign at_last = (elem_idx == IDX_W'(K - 1));
    assign full    = wr_en && at_last;

    // Write pointer: advances per accepted element, wraps only after slot K-1
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            elem_idx <= '0;
        end else if (wr_en) begin
            elem_idx <= at_last ? '0 : elem_idx + 1'b1;
        end
    end

    // Slot storage: holds the frame steady until the next element overwrites it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                slots[i] <= '0;
            end
        end else if (wr_en) begin
            slots[elem_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_flat
        assign frame[GAMMA*g +: GAMMA] = slots[g];
    end

endmodule

// File: rtl/mmh_sum_sequencer.sv
// Sequencer around the modular summation unit: packs K elements per frame,
// fires the summation, returns each sum as a hash word, N_BLOCKS words per
// key block. Optional feature macro: SUM_TIMEOUT_EN bounds the wait for the
// summation result to TIMEOUT cycles and raises the sticky err flag on expiry.
module mmh_sum_sequencer
    import mmh_pkg::*;
#(
    parameter int GAMMA    = DEF_GAMMA,
    parameter int K        = DEF_K,
    parameter int N_BLOCKS = DEF_N_BLOCKS,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input logic                clk,
    input logic                rst,
    mmh_sum_sequencer_if.slave bus
);
    localparam int BLK_W = cnt_width(N_BLOCKS);

    if (K < 2) begin : g_bad_k
        $error("mmh_sum_sequencer: K must be at least 2");
    end
    if (N_BLOCKS < 1) begin : g_bad_nblocks
        $error("mmh_sum_sequencer: N_BLOCKS must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mmh_sum_sequencer: TIMEOUT must be at least 1");
    end

    state_t           state, state_nxt;
    logic [BLK_W-1:0] blk_idx;
    logic [GAMMA-1:0] hash_q;
    logic             done_q;
    logic             frame_full;
    logic             last_blk;
    logic             accept_start;
    logic             word_taken;
    logic             capture;
    logic             timeout_hit;
    logic             elem_ready_c, sum_valid_in_c, hash_valid_c, hash_last_c, busy_c;

    assign last_blk     = (blk_idx == BLK_W'(N_BLOCKS - 1));
    assign accept_start = (state == ST_IDLE) && bus.start;
    assign word_taken   = (state == ST_OUT) && bus.hash_ready;
    assign capture      = (state == ST_WAIT) && bus.sum_valid_out;

    mmh_frame_packer #(
        .GAMMA (GAMMA),
        .K     (K)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept_start),
        .wr_en   (elem_ready_c && bus.elem_valid),
        .wr_data (bus.elem_data),
        .frame   (bus.sum_data),
        .full    (frame_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        state_nxt      = state;
        elem_ready_c   = 1'b0;
        sum_valid_in_c = 1'b0;
        hash_valid_c   = 1'b0;
        hash_last_c    = 1'b0;
        busy_c         = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                elem_ready_c = 1'b1;
                if (frame_full) state_nxt = ST_FIRE;
            end
            ST_FIRE: begin
                sum_valid_in_c = 1'b1;
                state_nxt      = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.sum_valid_out) state_nxt = ST_OUT;
                else if (timeout_hit)  state_nxt = ST_IDLE;
            end
            ST_OUT: begin
                hash_valid_c = 1'b1;
                hash_last_c  = last_blk;
                if (bus.hash_ready) state_nxt = last_blk ? ST_IDLE : ST_FILL;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Block counter: cleared by a new key block, advanced per accepted word
    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            blk_idx <= '0;
        end else if (word_taken && !last_blk) begin
            blk_idx <= blk_idx + 1'b1;
        end
    end

    // Hash word register and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            hash_q <= '0;
            done_q <= 1'b0;
        end else begin
            if (capture) hash_q <= bus.sum_result;
            done_q <= word_taken && last_blk;
        end
    end

`ifdef SUM_TIMEOUT_EN
    localparam int TO_W = cnt_width(TIMEOUT);

    logic [TO_W-1:0] wait_cnt;
    logic            err_q;

    assign timeout_hit = (state == ST_WAIT) && !bus.sum_valid_out &&
                         (wait_cnt == TO_W'(TIMEOUT - 1));

    // Counts WAIT cycles; restarts every time WAIT is left
    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky error: set on expiry, cleared only by the next accepted start
    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    assign bus.elem_ready   = elem_ready_c;
    assign bus.sum_valid_in = sum_valid_in_c;
    assign bus.hash_valid   = hash_valid_c;
    assign bus.hash_last    = hash_last_c;
    assign bus.hash_data    = hash_q;
    assign bus.busy         = busy_c;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_mmh_sum_sequencer.sv
// Self-checking bench for mmh_sum_sequencer with a mod-127 summation stub
// (one register on the input, one on the result) and a frame-level model.
module tb_mmh_sum_sequencer;
    import mmh_pkg::*;

    localparam int GAMMA = 13;
    localparam int K     = 16;
    localparam int NB    = 3;
    localparam int TO    = 15;
    localparam int P     = 127;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stub_silent = 1'b0;
    logic s1_v;
    logic [GAMMA-1:0] s1_res;

    int cyc       = 0;
    int fire_cnt  = 0;
    int done_cnt  = 0;
    int checks    = 0;
    int errors    = 0;
    int exp_done  = 0;
    int exp_fire  = 0;
    int t0, tguard;

    mmh_sum_sequencer_if #(.GAMMA(GAMMA), .K(K)) bus();

    mmh_sum_sequencer #(
        .GAMMA    (GAMMA),
        .K        (K),
        .N_BLOCKS (NB),
        .TIMEOUT  (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter and event counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.sum_valid_in) fire_cnt <= fire_cnt + 1;
        if (bus.done)         done_cnt <= done_cnt + 1;
    end

    function automatic logic [GAMMA-1:0] stubSum(input logic [GAMMA*K-1:0] f);
        int s;
        s = 0;
        for (int i = 0; i < K; i++) s += int'(f[GAMMA*i +: GAMMA]);
        return GAMMA'(s % P);
    endfunction

    // Summation unit stub: input register, then result register
    always @(posedge clk) begin
        if (rst) begin
            s1_v              <= 1'b0;
            s1_res            <= '0;
            bus.sum_valid_out <= 1'b0;
            bus.sum_result    <= '0;
        end else begin
            s1_v              <= bus.sum_valid_in && !stub_silent;
            s1_res            <= stubSum(bus.sum_data);
            bus.sum_valid_out <= s1_v;
            bus.sum_result    <= s1_res;
        end
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [GAMMA-1:0] pickValue(input int pattern, input int b);
        if (pattern == 1) begin
            if (b == 0) return GAMMA'(1);
            if (b == 1) return GAMMA'(100);
            return GAMMA'(127);
        end
        return GAMMA'($urandom);
    endfunction

    // Runs one key block of NB frames; called at a negedge with the DUT idle.
    // pattern 1: fixed values, 2: random with gaps and stray start, 3: continuous random
    task automatic applyStimulus(input int pattern, input int stall);
        int total, n, guard, acc, last_acc, exp_hash, fire_before;
        logic gap;
        logic [GAMMA-1:0] v;
        acc      = 0;
        last_acc = 0;
        bus.start      = 1'b1;
        bus.hash_ready = (stall == 0);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("busy_after_start", int'(bus.busy), 1);
        checkOutput("err_after_start", int'(bus.err), 0);
        for (int b = 0; b < NB; b++) begin
            total = 0;
            n = 0;
            guard = 0;
            fire_before = fire_cnt;
            while (n < K && guard < 400) begin
                gap = (pattern == 2) && ($urandom_range(0, 3) == 0);
                v = pickValue(pattern, b);
                bus.elem_valid = !gap;
                bus.elem_data  = v;
                if (pattern == 2) bus.start = 1'($urandom_range(0, 1));
                if (!gap) begin
                    checkOutput("elem_ready_fill", int'(bus.elem_ready), 1);
                    total += int'(v);
                    n++;
                    if (n == K) acc = cyc;
                end
                @(negedge clk);
                guard++;
            end
            bus.start      = 1'b0;
            bus.elem_valid = 1'b1;
            bus.elem_data  = GAMMA'($urandom);
            guard = 0;
            while (!bus.hash_valid && guard < 40) begin
                checkOutput("elem_ready_busy", int'(bus.elem_ready), 0);
                @(negedge clk);
                guard++;
            end
            exp_hash = total % P;
            checkOutput("hash_valid_rise", int'(bus.hash_valid), 1);
            checkOutput("hash_latency", cyc - acc - 1, 3);
            for (int s = 0; s < stall; s++) begin
                checkOutput("stall_hash_valid", int'(bus.hash_valid), 1);
                checkOutput("stall_hash_data", int'(bus.hash_data), exp_hash);
                checkOutput("stall_elem_ready", int'(bus.elem_ready), 0);
                @(negedge clk);
            end
            checkOutput("hash_data", int'(bus.hash_data), exp_hash);
            checkOutput("hash_last", int'(bus.hash_last), int'(b == NB - 1));
            checkOutput("fire_once", fire_cnt - fire_before, 1);
            exp_fire++;
            if (pattern == 3 && b > 0) checkOutput("frame_period", acc - last_acc, K + 4);
            last_acc = acc;
            bus.hash_ready = 1'b1;
            @(negedge clk);
            bus.hash_ready = (stall == 0);
            if (b == NB - 1) begin
                checkOutput("done_pulse", int'(bus.done), 1);
                checkOutput("busy_after_last", int'(bus.busy), 0);
                exp_done++;
                bus.elem_valid = 1'b0;
            end else begin
                checkOutput("done_quiet", int'(bus.done), 0);
                checkOutput("busy_between", int'(bus.busy), 1);
            end
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.elem_valid = 1'b0;
        bus.elem_data  = '0;
        bus.hash_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_done", int'(bus.done), 0);
        checkOutput("rst_hash_valid", int'(bus.hash_valid), 0);
        checkOutput("rst_hash_last", int'(bus.hash_last), 0);
        checkOutput("rst_hash_data", int'(bus.hash_data), 0);
        checkOutput("rst_elem_ready", int'(bus.elem_ready), 0);
        checkOutput("rst_sum_valid_in", int'(bus.sum_valid_in), 0);
        checkOutput("rst_sum_data", int'(|bus.sum_data), 0);
        checkOutput("rst_err", int'(bus.err), 0);
        rst = 1'b0;
        bus.elem_valid = 1'b1;
        @(negedge clk);
        checkOutput("idle_no_consume", int'(bus.elem_ready), 0);
        checkOutput("idle_busy", int'(bus.busy), 0);
        bus.elem_valid = 1'b0;

        $display("[TB] fixed-value block");
        applyStimulus(1, 0);
        $display("[TB] back-to-back continuous random block");
        applyStimulus(3, 0);
        @(negedge clk);
        checkOutput("done_one_cycle", int'(bus.done), 0);
        $display("[TB] random gaps with 10-cycle output stall");
        applyStimulus(2, 10);
        @(negedge clk);

        $display("[TB] reset in the middle of a frame");
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.elem_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.elem_data = GAMMA'($urandom);
            @(negedge clk);
        end
        bus.elem_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_hash_valid", int'(bus.hash_valid), 0);
        checkOutput("midrst_sum_data", int'(|bus.sum_data), 0);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(3, 0);
        @(negedge clk);

`ifdef SUM_TIMEOUT_EN
        $display("[TB] silent summation unit");
        stub_silent = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.elem_valid = 1'b1;
        for (int i = 0; i < K; i++) begin
            bus.elem_data = GAMMA'($urandom);
            @(negedge clk);
        end
        bus.elem_valid = 1'b0;
        exp_fire++;
        t0 = cyc;
        tguard = 0;
        while (bus.busy && tguard < 60) begin
            @(negedge clk);
            tguard++;
        end
        checkOutput("timeout_edges", cyc - t0, TO + 1);
        checkOutput("timeout_err", int'(bus.err), 1);
        checkOutput("timeout_no_done", int'(bus.done), 0);
        repeat (2) @(negedge clk);
        checkOutput("err_sticky", int'(bus.err), 1);
        stub_silent = 1'b0;
        applyStimulus(3, 0);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        checkOutput("done_total", done_cnt, exp_done);
        checkOutput("fire_total", fire_cnt, exp_fire);
        checkOutput("final_err", int'(bus.err), 0);
        checkOutput("final_idle", int'(bus.busy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
